// File: rtl/ffa2_postproc.sv
// Output combiner for the 2-parallel fast FIR: rebuilds the even/odd
// output pair from the three sub-filter results, then rounds, saturates and packs them.
module ffa2_postproc #(
  parameter int DWIDTH  = 16,
  parameter int DDWIDTH = 2*DWIDTH,
  parameter int AWIDTH  = 40,
  parameter int FRAC    = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [0:AWIDTH-1]  y0_in,
  input  logic [0:AWIDTH-1]  y01_in,
  input  logic [0:AWIDTH-1]  y1_in,
  input  logic               clr_ovf,
  output logic [0:DDWIDTH-1] data_out,
  output logic               out_valid,
  output logic               ovf_sticky
);

  localparam int W = AWIDTH + 2;

  localparam logic signed [W-1:0] RND =
    {{(W-1){1'b0}}, 1'b1} << (FRAC-1);

  localparam logic [DWIDTH-1:0] SMAX =
    {1'b0, {(DWIDTH-1){1'b1}}};
  localparam logic [DWIDTH-1:0] SMIN =
    {1'b1, {(DWIDTH-1){1'b0}}};

  logic [0:AWIDTH-1]  y1_d;
  logic signed [W-1:0] e0, e1, e01, e1d;
  logic signed [W-1:0] se_n, so_n;
  logic signed [W-1:0] se, so;
  logic                v1;
  logic signed [W-1:0] re, ro;
  logic                sat_e, sat_o;
  logic [DWIDTH-1:0]   qe, qo;

  // Stage 1 operands: sign-extend, then even/odd combinations
  always_comb begin
    e0   = W'($signed(y0_in));
    e1   = W'($signed(y1_in));
    e01  = W'($signed(y01_in));
    e1d  = W'($signed(y1_d));
    se_n = e0 + e1d;
    so_n = e01 - e0 - e1;
  end

  // Stage 1 registers and the sample-based y1 delay
  always_ff @(posedge clk) begin
    if (rst) begin
      y1_d <= '0;
      se   <= '0;
      so   <= '0;
      v1   <= 1'b0;
    end else begin
      v1 <= in_valid;
      if (in_valid) begin
        y1_d <= y1_in;
        se   <= se_n;
        so   <= so_n;
      end
    end
  end

  // Stage 2 combinational: round half up, then clamp to DWIDTH
  always_comb begin
    re    = (se + RND) >>> FRAC;
    ro    = (so + RND) >>> FRAC;
    sat_e = !((&re[W-1:DWIDTH-1]) || !(|re[W-1:DWIDTH-1]));
    sat_o = !((&ro[W-1:DWIDTH-1]) || !(|ro[W-1:DWIDTH-1]));
    qe    = re[DWIDTH-1:0];
    qo    = ro[DWIDTH-1:0];
    if (sat_e) qe = re[W-1] ? SMIN : SMAX;
    if (sat_o) qo = ro[W-1] ? SMIN : SMAX;
  end

  // Stage 2 registers: packed output, valid strobe, sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= '0;
      out_valid  <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      out_valid <= v1;
      if (v1) data_out <= {qe, qo};
      if (v1 && (sat_e || sat_o)) ovf_sticky <= 1'b1;
      else if (clr_ovf)           ovf_sticky <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ffa2_postproc.sv
// Directed bench for ffa2_postproc: reconstruction, y1 delay,
// bubbles, rounding, saturation/sticky flag and mid-stream reset.
module tb_ffa2_postproc;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [0:39] y0_in, y01_in, y1_in;
  logic        clr_ovf;
  logic [0:31] data_out;
  logic        out_valid;
  logic        ovf_sticky;

  int checks   = 0;
  int failures = 0;

  ffa2_postproc dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .y0_in      (y0_in),
    .y01_in     (y01_in),
    .y1_in      (y1_in),
    .clr_ovf    (clr_ovf),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .ovf_sticky (ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint even_s();
    logic signed [15:0] v;
    v = data_out[0:15];
    return longint'(v);
  endfunction

  function automatic longint odd_s();
    logic signed [15:0] v;
    v = data_out[16:31];
    return longint'(v);
  endfunction

  task automatic drive(input bit v, input longint a,
                       input longint b, input longint c);
    in_valid = v;
    y0_in    = 40'(a);
    y1_in    = 40'(b);
    y01_in   = 40'(c);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // one sample, then idle; output visible on return
  task automatic send(input longint a, input longint b,
                      input longint c);
    drive(1'b1, a, b, c);
    step();
    in_valid = 1'b0;
    step();
  endtask

  bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    rst = 1'b1;
    clr_ovf = 1'b0;
    drive(1'b0, 0, 0, 0);
    step();
    step();
    rst = 1'b0;
    chk("rst_data", longint'(data_out), 0);
    chk("rst_ov", longint'(out_valid), 0);
    chk("rst_ovf", longint'(ovf_sticky), 0);

    // back-to-back A then B
    drive(1'b1, 98304, 32768, 196608);
    step();
    drive(1'b1, 32768, 65536, 163840);
    step();
    chk("a_ov", longint'(out_valid), 1);
    chk("a_even", even_s(), 3);
    chk("a_odd", odd_s(), 2);
    in_valid = 1'b0;
    step();
    chk("b_ov", longint'(out_valid), 1);
    chk("b_even", even_s(), 2);
    chk("b_odd", odd_s(), 2);
    step();
    chk("b_ov_lo", longint'(out_valid), 0);
    chk("b_hold", even_s(), 2);

    // same pair with three bubbles between
    do_reset();
    for (int j = 0; j < 7; j++) begin
      if (j == 0)      drive(1'b1, 98304, 32768, 196608);
      else if (j == 4) drive(1'b1, 32768, 65536, 163840);
      else drive(1'b0, longint'($urandom), 12345, 777);
      step();
      if (j >= 1)
        chk($sformatf("bub_ov%0d", j), longint'(out_valid),
            longint'(pat[j-1]));
      if (j == 1) begin
        chk("bub_a_even", even_s(), 3);
        chk("bub_a_odd", odd_s(), 2);
      end
      if (j == 4) begin
        chk("bub_hold_e", even_s(), 3);
        chk("bub_hold_o", odd_s(), 2);
      end
      if (j == 5) begin
        chk("bub_b_even", even_s(), 2);
        chk("bub_b_odd", odd_s(), 2);
      end
    end

    // rounding
    do_reset();
    send(16384, 0, -16384);
    chk("rnd1_even", even_s(), 1);
    chk("rnd1_odd", odd_s(), -1);
    send(-16384, 0, 16384);
    chk("rnd2_even", even_s(), 0);
    chk("rnd2_odd", odd_s(), 1);
    send(49152, 0, -49152);
    chk("rnd3_even", even_s(), 2);
    chk("rnd3_odd", odd_s(), -3);
    chk("rnd_ovf", longint'(ovf_sticky), 0);

    // saturation and sticky flag
    send(40000 * 32768, 0, 0);
    chk("sat_even", even_s(), 32767);
    chk("sat_odd", odd_s(), -32768);
    chk("sat_ovf", longint'(ovf_sticky), 1);
    send(32768, 0, -32768);
    chk("post_even", even_s(), 1);
    chk("post_odd", odd_s(), -2);
    chk("post_ovf", longint'(ovf_sticky), 1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("clr_ovf", longint'(ovf_sticky), 0);
    drive(1'b1, 40000 * 32768, 0, 0);
    step();
    in_valid = 1'b0;
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("setwins_ovf", longint'(ovf_sticky), 1);

    // reset with two samples in flight
    drive(1'b1, 65536, 65536, 0);
    step();
    drive(1'b1, 65536, 65536, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("mrst_ov0", longint'(out_valid), 0);
    chk("mrst_data", longint'(data_out), 0);
    chk("mrst_ovf", longint'(ovf_sticky), 0);
    step();
    chk("mrst_ov1", longint'(out_valid), 0);
    send(98304, 0, 0);
    chk("mrst_ov2", longint'(out_valid), 1);
    chk("mrst_even", even_s(), 3);
    chk("mrst_odd", odd_s(), -3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
